// File: rtl/gearbox_down_if.sv
// Stream bundle for the 20-to-16 gearbox: input side, output side and fill level.
// GEARBOX_DOWN_FLUSH_EN adds the flush request to the bundle.
interface gearbox_down_if #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16,
  parameter int FW    = $clog2(IN_W + OUT_W + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  data_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] data_out;
  logic [FW-1:0]    fill;
`ifdef GEARBOX_DOWN_FLUSH_EN
  logic             flush;

  modport slave (
    input  in_valid, data_in, out_ready, flush,
    output in_ready, out_valid, data_out, fill
  );
  modport master (
    output in_valid, data_in, out_ready, flush,
    input  in_ready, out_valid, data_out, fill
  );
`else
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, fill
  );
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, fill
  );
`endif
endinterface

// File: rtl/gearbox_down.sv
// IN_W-to-OUT_W LSB-first width converter over an IN_W+OUT_W bit buffer.
// GEARBOX_DOWN_FLUSH_EN adds a flush input that emits a zero-padded final word.
module gearbox_down #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input logic           clk,
  input logic           res,
  gearbox_down_if.slave bus
);
  localparam int BUF_W = IN_W + OUT_W;
  localparam int FW    = $clog2(BUF_W + 1);

  localparam logic [FW-1:0] OUT_C = FW'(OUT_W);
  localparam logic [FW:0]   IN_X  = (FW+1)'(IN_W);
  localparam logic [FW:0]   BUF_X = (FW+1)'(BUF_W);

  logic [BUF_W-1:0] sbuf_q, sbuf_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [FW-1:0]    avail;
  logic [OUT_W-1:0] dmask;
  logic             full_w, part_w, ov_w;
  logic             ofire, ifire, ir_w, blk_w;

  assign full_w = (fill_q >= OUT_C);
`ifdef GEARBOX_DOWN_FLUSH_EN
  assign part_w = bus.flush & (fill_q != '0) & ~full_w;
  assign blk_w  = bus.flush;
`else
  assign part_w = 1'b0;
  assign blk_w  = 1'b0;
`endif
  assign ov_w  = full_w | part_w;
  assign ofire = ov_w & bus.out_ready;

  // A flushed partial word empties the buffer completely.
  always_comb begin
    avail = fill_q;
    if (ofire) begin
      avail = full_w ? (fill_q - OUT_C) : '0;
    end
  end

  assign ir_w = ~res & ~blk_w
              & (({1'b0, avail} + IN_X) <= BUF_X);
  assign ifire = bus.in_valid & ir_w;

  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      dmask[i] = (i < int'(fill_q));
    end
  end

  assign bus.in_ready  = ir_w;
  assign bus.out_valid = ov_w;
  assign bus.data_out  = sbuf_q[OUT_W-1:0] & dmask;
  assign bus.fill      = fill_q;

  always_comb begin
    sbuf_d = sbuf_q;
    fill_d = fill_q;
    if (ofire) begin
      sbuf_d = full_w ? (sbuf_q >> OUT_W) : '0;
      fill_d = avail;
    end
    if (ifire) begin
      sbuf_d[avail +: IN_W] = bus.data_in;
      fill_d = avail + FW'(IN_W);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sbuf_q <= '0;
      fill_q <= '0;
    end else begin
      sbuf_q <= sbuf_d;
      fill_q <= fill_d;
    end
  end
endmodule
